// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial UART transmitter.
//
// Sits downstream of the MMIO UART register block. It accepts a one-cycle
// tx_start pulse together with tx_data, and then shifts out one frame:
// a start bit (0), eight data bits LSB first, and a stop bit (1). Each bit
// is held for CLKS_PER_BIT clock cycles. While a frame is on the line,
// busy is high and further tx_start pulses are ignored.
//
// Ports:
//   clk       in   1  system clock, all logic on the rising edge
//   reset     in   1  synchronous, active-high reset
//   tx_start  in   1  one-cycle send request, honoured only in IDLE
//   tx_data   in   8  byte to send, sampled only on the accepting edge
//   tx        out  1  serial line, idle-high (registered)
//   busy      out  1  high for the 10*CLKS_PER_BIT cycles of a frame (registered)

module uart_tx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy
);

  // Truncating division; the integrator must keep this >= 2.
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned IDX_W        = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q,    tx_d;
  logic                busy_q,  busy_d;
  logic                baud_last;

  // End of the current bit period.
  assign baud_last = (cnt_q == CNT_LAST);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic. tx/busy are computed one cycle early
  // so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (tx_start) begin
          shift_d = tx_data;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (baud_last) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (baud_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            // Next bit is what lands in shift_q[0] after this shift.
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (baud_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT = 4 (CLK_FREQ=1000, BAUD_RATE=250).
// Outputs are sampled 1 time unit after each rising edge.

module tb_uart_tx;

  localparam int unsigned CPB     = 4;
  localparam int unsigned FRAME_N = 10 * CPB;

  logic       clk;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_tx #(
    .CLK_FREQ (1000),
    .BAUD_RATE(250)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send byte d and check the full frame. If inject_at >= 0, a tx_start with
  // 0xFF is pulsed at that cycle of the frame (must be ignored). tx_data is
  // scrambled after acceptance to show only the latched copy is shifted.
  task automatic run_frame(input string tag, input logic [7:0] d, input int inject_at);
    logic [FRAME_N-1:0] tx_vec;
    logic [FRAME_N-1:0] busy_vec;
    logic [FRAME_N-1:0] exp_vec;
    logic [7:0]         rx;
    int                 bitn;

    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    tx_data  = ~d;

    for (int i = 0; i < int'(FRAME_N); i++) begin
      tx_vec[i]   = tx;
      busy_vec[i] = busy;
      bitn = i / int'(CPB);
      if (bitn == 0)      exp_vec[i] = 1'b0;
      else if (bitn == 9) exp_vec[i] = 1'b1;
      else                exp_vec[i] = d[bitn-1];
      if (i == inject_at) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end
      step();
      tx_start = 1'b0;
    end

    // Receive model: sample the middle of each data bit.
    for (int k = 0; k < 8; k++) rx[k] = tx_vec[(k + 1) * int'(CPB) + 2];

    check({tag, " tx waveform"}, 64'(tx_vec), 64'(exp_vec));
    check({tag, " busy high"},   64'(busy_vec), 64'({FRAME_N{1'b1}}));
    check({tag, " decode"},      64'(rx), 64'(d));
    check({tag, " busy falls"},  64'(busy), 64'(0));
    check({tag, " tx idle"},     64'(tx), 64'(1));
  endtask

  initial begin
    logic any_busy;

    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) step();
    check("reset tx",   64'(tx),   64'(1));
    check("reset busy", 64'(busy), 64'(0));

    // 1: idle after reset holds for 20 cycles.
    reset = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0 || tx !== 1'b1) any_busy = 1'b1;
    end
    check("idle hold", 64'(any_busy), 64'(0));

    // 2, 3: basic frames.
    run_frame("t2 0x55", 8'h55, -1);
    step();
    run_frame("t3 0xA3", 8'hA3, -1);
    step();

    // 4: tx_start mid-frame is ignored and does not queue a second frame.
    run_frame("t4 0x55", 8'h55, 10);
    any_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0 || tx !== 1'b1) any_busy = 1'b1;
      step();
    end
    check("t4 no second frame", 64'(any_busy), 64'(0));

    // 5: reset at cycle 17 aborts; tx_start coincident with reset ignored.
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (17) step();
    check("t5 mid-frame busy", 64'(busy), 64'(1));
    reset    = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'h99;
    step();
    check("t5 reset tx",   64'(tx),   64'(1));
    check("t5 reset busy", 64'(busy), 64'(0));
    reset    = 1'b0;
    tx_start = 1'b0;
    step();
    check("t5 post-reset busy", 64'(busy), 64'(0));
    run_frame("t5 0x3C", 8'h3C, -1);
    step();

    // 6: back-to-back frames separated by exactly one idle cycle.
    run_frame("t6 0x12", 8'h12, -1);
    run_frame("t6 0x34", 8'h34, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter, 8N1 format. It sits directly downstream of the MMIO UART register block. It consumes that block's one-cycle tx_start pulse and tx_data byte, and returns busy, which gates further writes and is readable at the UART status register. It drives the board-level TX pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE, integer division (truncating); clock cycles per serial bit; must be >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
tx_start  input  1  one-cycle request to send tx_data; honoured only in IDLE.
tx_data  input  8  byte to send; sampled only on the accepting edge.
tx  output  1  serial line; idle-high.
busy  output  1  high from the cycle after accept until the frame completes.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. On a reset edge: tx=1, busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- tx and busy are registered outputs; no combinational path from any input to any output.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift_reg[0].
  - STOP: tx=1.
- Accept: on an edge in IDLE with tx_start=1, latch tx_data into the shift register. After that edge: state=START, busy=1, tx=0, baud counter=0, bit index=0.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in START, DATA and STOP.
  - At terminal count (CLKS_PER_BIT-1) it wraps to 0 and the bit advances.
  - Each bit is driven for exactly CLKS_PER_BIT cycles.
- START terminal: go to DATA; tx takes data bit 0 (LSB first).
- DATA terminal:
  - Shift the register right.
  - If bit index = 7: go to STOP.
  - Otherwise: increment bit index.
- STOP terminal: go to IDLE; busy=0, tx=1.
- Frame timing: busy is high for exactly 10*CLKS_PER_BIT cycles. The first tx=0 cycle coincides with the first busy=1 cycle.
- tx_start while state != IDLE: ignored. No data latched, no queueing, frame unaffected.
- Back-to-back frames: accept is only legal in IDLE, so at least one IDLE cycle (tx=1, busy=0) separates frames. A tx_start in the first IDLE cycle after STOP is accepted.
- tx_data changing mid-frame: no effect; only the latched copy is shifted.
- Reset mid-frame: the frame is aborted at that edge. tx=1 and busy=0 on the next cycle. Any tx_start asserted in the same cycle as reset is ignored.
- tx_start held high for multiple cycles: the first IDLE edge accepts. After the frame, if still high in IDLE, a second identical frame starts. The upstream pulses for one cycle only.

Test Plan:
1. Reset with tx_start=0 -> tx=1, busy=0; they hold for 20 cycles.
2. Parameters CLK_FREQ=1000, BAUD_RATE=250 (CLKS_PER_BIT=4). Pulse tx_start with tx_data=0x55 -> next cycle busy=1. tx = 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each for exactly 4 cycles. busy falls after 40 cycles.
3. Same parameters, tx_data=0xA3 -> data bits LSB first 1,1,0,0,0,1,0,1. Bench UART receive model decodes 0xA3.
4. Pulse tx_start=1 with tx_data=0xFF at cycle 10 of a 0x55 frame -> ignored. The frame still decodes 0x55, busy falls at cycle 40, and no second frame starts.
5. Assert reset at cycle 17 of a frame -> tx=1 and busy=0 on the next cycle. A new tx_start with 0x3C after reset releases sends a clean 0x3C frame.
6. Pulse tx_start (0x12) in the first cycle busy=0, then pulse again (0x34) in the first IDLE cycle after that frame -> two frames decode 0x12 then 0x34, separated by exactly 1 idle-high cycle.
